counter_meas_ctrl: RTL
======================

Name: counter_meas_ctrl

Overview:
- Measurement sequencer for a 32-bit up-counter with enable and synchronous clear inputs.
- Each measurement: clear the counter, gate the enable with an external qualifier for a programmable window of cycles, capture the final count, present it with a valid/ack handshake.
- Supports single-shot and auto-repeat modes plus abort. Sits between control/register logic and the counter instance.

Parameters:
DATA_WIDTH, 32, width of the counter value and captured result
WIN_WIDTH, 16, width of the window-length input

Ports:
clock  input  1  system clock, all state changes on rising edge
i_reset  input  1  reset; one clock; reset is asynchronous and active-low
i_start  input  1  level-sampled start request, honoured in IDLE only
i_stop  input  1  abort; priority over every other control input
i_auto  input  1  auto-repeat enable, sampled on the ack edge
i_window  input  WIN_WIDTH  window length in cycles, latched on accepted start
i_sw  input  1  count qualifier, passed to counter only in RUN
i_count_data  input  DATA_WIDTH  registered counter value
o_sw  output  1  counter enable = (state==RUN) & i_sw, combinational
o_comp_reset  output  1  counter synchronous clear, high in IDLE and CLEAR
o_result  output  DATA_WIDTH  captured count, stable while o_valid
o_overflow  output  1  counter wrapped during this window, qualified by o_valid
o_valid  output  1  result available
i_ack  input  1  consumer accepts result when o_valid & i_ack at an edge
o_busy  output  1  high in CLEAR, RUN, SETTLE

Behaviour:
- Reset (i_reset=0, async):
  - state=IDLE, window register=0, run counter=0.
  - o_result=0, o_overflow=0, o_valid=0.
  - o_comp_reset=1, o_sw=0, o_busy=0.
- IDLE:
  - o_comp_reset=1, so the counter is held at 0.
  - i_start=1 and i_stop=0: latch i_window, go to CLEAR.
- CLEAR (1 cycle):
  - o_comp_reset=1, clear the overflow tracker, load the run counter with the latched window.
  - Window==0: go straight to SETTLE. Otherwise go to RUN.
- RUN (exactly N = latched window cycles):
  - o_comp_reset=0, o_sw=i_sw.
  - Decrement the run counter each cycle; leave after the cycle in which it reaches 1.
  - Overflow tracker sets if o_sw=1 and i_count_data = all-ones in any RUN cycle.
- SETTLE (1 cycle):
  - o_sw=0.
  - On exit, capture i_count_data into o_result and the tracker into o_overflow; go to DONE.
- DONE:
  - o_valid=1, o_sw=0, o_comp_reset=0, so the counter holds its value.
  - On an edge with i_ack=1: o_valid=0 at that edge. Go to CLEAR if i_auto=1, else IDLE.
- Latency: o_valid rises N+2 cycles after the edge that accepts start.
  - o_result = number of RUN cycles with i_sw=1, modulo 2^DATA_WIDTH.
- i_stop=1 in any non-IDLE state:
  - Next state is IDLE; o_valid drops at that edge.
  - o_result and o_overflow keep their last value; no new result is produced.
- i_start outside IDLE is ignored; a start is not queued.
- i_window changes after acceptance have no effect until the next CLEAR.
- In auto-repeat, the next window reuses the latched i_window value; it is re-latched only from IDLE.
- Reset mid-operation aborts immediately to reset values. No partial result is presented.
- Same-edge events:
  - i_ack and i_stop: stop wins; next state is IDLE even when i_auto=1.
  - i_start and i_stop in IDLE: stay in IDLE.

Test Plan:
- Reset during RUN (window=1000, after 10 RUN cycles) -> all outputs take reset values asynchronously, o_comp_reset=1. After release with no start, stays IDLE.
- Window=8, i_sw=1 throughout, start pulse -> o_valid rises 10 cycles after the start edge, o_result=8, o_overflow=0. Hold i_ack=0 for 5 cycles: o_result stays stable. Ack -> o_valid=0, IDLE.
- Window=10, i_sw toggling 1,0,1,0... -> o_result=5. i_auto=1 at ack -> second result 5 follows exactly 12 cycles after the ack edge with no start pulse.
- Window=0 -> o_valid 2 cycles after start, o_result=0. Start asserted while busy -> ignored, exactly one result produced.
- Window=5, i_sw=1, counter model preloaded to 0xFFFFFFFE at RUN entry by forcing the counter model -> o_result=3 (wrapped), o_overflow=1.
- i_stop in cycle 3 of RUN (window=20) -> IDLE next edge, o_valid never rises, o_comp_reset=1. i_stop together with i_ack in DONE while i_auto=1 -> IDLE, no restart.

Source files
------------

// File: rtl/counter_meas_ctrl.sv
// ---------------------------------------------------------------------------
// counter_meas_ctrl
//
// Measurement sequencer wrapped around an external 32-bit up-counter.
// A measurement proceeds as follows:
//   1. Clear the counter.
//   2. Let the counter run, gated by an external qualifier, for a
//      programmable number of cycles.
//   3. Capture the final count.
//   4. Hold the captured count behind a valid/ack handshake.
// Single-shot and auto-repeat operation are supported, and a measurement
// can be aborted at any point.
//
// Ports:
//   clock         system clock, rising edge
//   i_reset       asynchronous active-low reset
//   i_start       start request, honoured only when idle
//   i_stop        abort, overrides every other control input
//   i_auto        auto-repeat enable, sampled when a result is acknowledged
//   i_window      window length in cycles, latched when a start is accepted
//   i_sw          count qualifier, forwarded to the counter only while running
//   i_count_data  current (registered) counter value
//   o_sw          counter enable
//   o_comp_reset  counter synchronous clear
//   o_result      captured count, stable while o_valid is high
//   o_overflow    counter wrapped during the window, qualified by o_valid
//   o_valid       result available
//   i_ack         consumer accepts the result when o_valid & i_ack
//   o_busy        a measurement is in progress
// ---------------------------------------------------------------------------
module counter_meas_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int WIN_WIDTH  = 16
) (
   input  logic                  clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic                  i_stop,
   input  logic                  i_auto,
   input  logic [WIN_WIDTH-1:0]  i_window,
   input  logic                  i_sw,
   input  logic [DATA_WIDTH-1:0] i_count_data,
   output logic                  o_sw,
   output logic                  o_comp_reset,
   output logic [DATA_WIDTH-1:0] o_result,
   output logic                  o_overflow,
   output logic                  o_valid,
   input  logic                  i_ack,
   output logic                  o_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t                  state_q,     state_d;
   logic [WIN_WIDTH-1:0]    window_q,    window_d;
   logic [WIN_WIDTH-1:0]    run_cnt_q,   run_cnt_d;
   logic                    ovf_track_q, ovf_track_d;
   logic [DATA_WIDTH-1:0]   result_q,    result_d;
   logic                    overflow_q,  overflow_d;
   logic                    valid_q,     valid_d;

   // An increment while the counter reads all-ones is exactly a wrap.
   logic count_full;
   assign count_full = &i_count_data;

   // Next-state and datapath logic. Abort is checked first so that it
   // overrides start, ack and auto-repeat in every busy or done state.
   always_comb begin
      state_d     = state_q;
      window_d    = window_q;
      run_cnt_d   = run_cnt_q;
      ovf_track_d = ovf_track_q;
      result_d    = result_q;
      overflow_d  = overflow_q;
      valid_d     = valid_q;

      if (state_q != S_IDLE && i_stop) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start && !i_stop) begin
                  window_d = i_window;
                  state_d  = S_CLEAR;
               end
            end

            S_CLEAR: begin
               ovf_track_d = 1'b0;
               run_cnt_d   = window_q;
               state_d     = (window_q == '0) ? S_SETTLE : S_RUN;
            end

            S_RUN: begin
               run_cnt_d = run_cnt_q - WIN_WIDTH'(1);
               if (i_sw && count_full) begin
                  ovf_track_d = 1'b1;
               end
               // The cycle in which the counter reads 1 is the last one.
               if (run_cnt_q == WIN_WIDTH'(1)) begin
                  state_d = S_SETTLE;
               end
            end

            // The counter has absorbed the last enabled increment by now.
            S_SETTLE: begin
               result_d   = i_count_data;
               overflow_d = ovf_track_q;
               valid_d    = 1'b1;
               state_d    = S_DONE;
            end

            S_DONE: begin
               if (i_ack) begin
                  valid_d = 1'b0;
                  state_d = i_auto ? S_CLEAR : S_IDLE;
               end
            end

            default: begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and result registers; reset returns everything to idle with no
   // result pending.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= S_IDLE;
         window_q    <= '0;
         run_cnt_q   <= '0;
         ovf_track_q <= 1'b0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         window_q    <= window_d;
         run_cnt_q   <= run_cnt_d;
         ovf_track_q <= ovf_track_d;
         result_q    <= result_d;
         overflow_q  <= overflow_d;
         valid_q     <= valid_d;
      end
   end

   // Counter controls are decoded from the state register only; o_sw must
   // follow i_sw in the same cycle, so it stays combinational.
   assign o_sw         = (state_q == S_RUN) & i_sw;
   assign o_comp_reset = (state_q == S_IDLE) | (state_q == S_CLEAR);
   assign o_busy       = (state_q == S_CLEAR) | (state_q == S_RUN) |
                         (state_q == S_SETTLE);
   assign o_result     = result_q;
   assign o_overflow   = overflow_q;
   assign o_valid      = valid_q;

endmodule
